// File: rtl/switch_control_pkg.sv
// switch_control_pkg
//   Shared definitions for the router switch control slice: port count,
//   default flit width, port index encodings and the control FSM states.
package switch_control_pkg;

    localparam int NPORT        = 5;
    localparam int TAM_FLIT_DEF = 16;

    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_ROUTE = 2'd2,
        S_GRANT = 2'd3
    } state_t;

endpackage

// File: rtl/switch_control_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker over NPORT requests.
//   Ports:
//     req   - request vector, one bit per input port
//     last  - index granted most recently; search starts at (last+1) mod NPORT
//     sel   - first requesting index found (holds last when nothing requests)
//     valid - at least one request bit is set
module rr_arbiter
    import switch_control_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic [2:0]       last,
    output logic [2:0]       sel,
    output logic             valid
);

    logic [2:0] idx;

    // Walk from the farthest offset down to the nearest so the closest
    // requester after 'last' is the final (winning) assignment.
    always_comb begin
        sel   = last;
        valid = 1'b0;
        idx   = '0;
        for (int i = NPORT; i >= 1; i--) begin
            idx = 3'((int'(last) + i) % NPORT);
            if (req[idx]) begin
                sel   = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_control.sv
// switch_control
//   Central allocator of an XY-routed mesh router. Picks one waiting header
//   round-robin, routes it XY against ADDRESS, and if the chosen output is
//   free connects input->output through the mux selects. Outputs are
//   released when the owning input's sender line falls.
//   Ports:
//     clock   - single clock, rising edge
//     reset   - asynchronous, active low
//     h       - per input: an unrouted header waits at the buffer head
//     ack_h   - per input: one-cycle header-accept pulse
//     data    - head flit of each input (input p at [TAM_FLIT*(p+1)-1:TAM_FLIT*p])
//     sender  - per input: still transmitting a granted packet
//     free    - per output: unallocated
//     mux_in  - per output, 3 bits: source input index
//     mux_out - per input, 3 bits: destination output index
module switch_control
    import switch_control_pkg::*;
#(
    parameter logic [7:0] ADDRESS  = 8'h00,
    parameter int         TAM_FLIT = TAM_FLIT_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NPORT-1:0]          h,
    output logic [NPORT-1:0]          ack_h,
    input  logic [NPORT*TAM_FLIT-1:0] data,
    input  logic [NPORT-1:0]          sender,
    output logic [NPORT-1:0]          free,
    output logic [3*NPORT-1:0]        mux_in,
    output logic [3*NPORT-1:0]        mux_out
);

    logic [NPORT-1:0][TAM_FLIT-1:0] data_a;
    logic                           data_unused;

    state_t                  state_q, state_d;
    logic [2:0]              sel_q, sel_d;
    logic [2:0]              last_q, last_d;
    logic [NPORT-1:0]        free_q, free_d;
    logic [NPORT-1:0]        ack_h_q, ack_h_d;
    logic [NPORT-1:0]        sender_dly_q, sender_dly_d;
    logic [NPORT-1:0][2:0]   mux_in_q, mux_in_d;
    logic [NPORT-1:0][2:0]   mux_out_q, mux_out_d;

    logic [2:0] arb_sel;
    logic       arb_valid;
    logic [7:0] tgt;
    logic [2:0] dest;

    assign data_a      = data;
    // Only the low address byte of each flit matters here.
    assign data_unused = ^data;

    rr_arbiter u_arb (
        .req   (h),
        .last  (last_q),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    // XY routing: resolve X first, then Y.
    always_comb begin
        tgt = data_a[sel_q][7:0];
        if (tgt[7:4] == ADDRESS[7:4] && tgt[3:0] == ADDRESS[3:0])
            dest = LOCAL;
        else if (ADDRESS[7:4] < tgt[7:4])
            dest = EAST;
        else if (ADDRESS[7:4] > tgt[7:4])
            dest = WEST;
        else if (ADDRESS[3:0] < tgt[3:0])
            dest = NORTH;
        else
            dest = SOUTH;
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        free_d       = free_q;
        ack_h_d      = '0;
        mux_in_d     = mux_in_q;
        mux_out_d    = mux_out_q;
        sender_dly_d = sender;

        // Release on the falling edge of the owner's sender line.
        for (int o = 0; o < NPORT; o++) begin
            if (!free_q[o] && sender_dly_q[mux_in_q[o]] && !sender[mux_in_q[o]])
                free_d[o] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (|h) state_d = S_ARB;
            end
            S_ARB: begin
                if (arb_valid) begin
                    sel_d   = arb_sel;
                    state_d = S_ROUTE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROUTE: begin
                // Grant outputs are loaded on entry to GRANT so they are
                // visible as registers throughout the GRANT cycle. free_q is
                // the pre-release value, so a release this edge never
                // collides with a grant of the same output.
                last_d = sel_q;
                if (free_q[dest]) begin
                    state_d          = S_GRANT;
                    ack_h_d[sel_q]   = 1'b1;
                    mux_in_d[dest]   = sel_q;
                    mux_out_d[sel_q] = dest;
                    free_d[dest]     = 1'b0;
                end else begin
                    // Busy output: give up this round; the header stays
                    // pending and others get the next turn.
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            last_q       <= LOCAL;
            free_q       <= '1;
            ack_h_q      <= '0;
            mux_in_q     <= '0;
            mux_out_q    <= '0;
            sender_dly_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            free_q       <= free_d;
            ack_h_q      <= ack_h_d;
            mux_in_q     <= mux_in_d;
            mux_out_q    <= mux_out_d;
            sender_dly_q <= sender_dly_d;
        end
    end

    assign ack_h   = ack_h_q;
    assign free    = free_q;
    assign mux_in  = mux_in_q;
    assign mux_out = mux_out_q;

endmodule

// File: tb/tb_switch_control.sv
// tb_switch_control
//   Scoreboard bench for switch_control at ADDRESS=8'h11. Tasks push the
//   grants they expect; a negedge monitor pops and compares each grant as
//   ack_h fires, and drops the header of the acked input.
module tb_switch_control;
    import switch_control_pkg::*;

    localparam int TF = 16;

    typedef struct {
        int idx;
        int dest;
        int cyc;   // expected ack cycle, -1 = any
    } grant_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [4:0]      h;
    logic [4:0]      sender = '0;
    logic [5*TF-1:0] data = '0;
    logic [4:0]      ack_h;
    logic [4:0]      free;
    logic [14:0]     mux_in;
    logic [14:0]     mux_out;

    grant_t exp_q[$];
    grant_t mon_e;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     n_grants = 0;
    int     req_cnt[5] = '{0, 0, 0, 0, 0};
    int     ack_cnt[5] = '{0, 0, 0, 0, 0};

    switch_control #(.ADDRESS(8'h11), .TAM_FLIT(TF)) dut (
        .clock   (clock),
        .reset   (reset),
        .h       (h),
        .ack_h   (ack_h),
        .data    (data),
        .sender  (sender),
        .free    (free),
        .mux_in  (mux_in),
        .mux_out (mux_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // A header is pending while more requests were issued than acked.
    always_comb begin
        h = '0;
        for (int p = 0; p < 5; p++) h[p] = (req_cnt[p] != ack_cnt[p]);
    end

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (ack_h !== 5'b0) begin
            checks++;
            if ($countones(ack_h) != 1) begin
                errors++;
                $display("FAIL grant_onehot: ack_h=%b, required exactly one bit", ack_h);
            end
            for (int p = 0; p < 5; p++) begin
                if (ack_h[p] === 1'b1) begin
                    n_grants++;
                    ack_cnt[p] = ack_cnt[p] + 1;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL grant_unexpected: ack on input %0d at cycle %0d, required none", p, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (p != mon_e.idx) begin
                            errors++;
                            $display("FAIL grant_input: got %0d, required %0d", p, mon_e.idx);
                        end
                        checks++;
                        if (mux_out[p*3 +: 3] !== 3'(mon_e.dest)) begin
                            errors++;
                            $display("FAIL grant_mux_out: got %0d, required %0d", mux_out[p*3 +: 3], mon_e.dest);
                        end
                        checks++;
                        if (mux_in[mon_e.dest*3 +: 3] !== 3'(mon_e.idx)) begin
                            errors++;
                            $display("FAIL grant_mux_in: got %0d, required %0d", mux_in[mon_e.dest*3 +: 3], mon_e.idx);
                        end
                        checks++;
                        if (free[mon_e.dest] !== 1'b0) begin
                            errors++;
                            $display("FAIL grant_free: free=%b, required bit %0d low", free, mon_e.dest);
                        end
                        if (mon_e.cyc >= 0) begin
                            checks++;
                            if (cyc != mon_e.cyc) begin
                                errors++;
                                $display("FAIL grant_latency: ack at cycle %0d, required %0d", cyc, mon_e.cyc);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic set_target(input int p, input logic [7:0] t);
        data[p*TF +: TF] = {8'h00, t};
    endtask

    task automatic request(input int p);
        req_cnt[p] = req_cnt[p] + 1;
    endtask

    task automatic wait_drain(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock); #1;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        sender = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock); #1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (free !== 5'b11111) begin errors++; $display("FAIL reset_free: got %b, required 11111", free); end
        checks++;
        if (ack_h !== 5'b0) begin errors++; $display("FAIL reset_ack: got %b, required 00000", ack_h); end
        checks++;
        if (mux_in !== 15'd0) begin errors++; $display("FAIL reset_mux_in: got %h, required 0", mux_in); end
        checks++;
        if (mux_out !== 15'd0) begin errors++; $display("FAIL reset_mux_out: got %h, required 0", mux_out); end
        reset = 1'b1;
        @(negedge clock); #1;
    endtask

    task automatic test_local_and_release();
        set_target(4, 8'h11);
        @(negedge clock);
        request(4);
        exp_q.push_back('{4, 4, cyc + 3});
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL local_timeout: %0d grants outstanding, required 0", exp_q.size()); end
        // Packet streams for a cycle then ends.
        @(negedge clock); sender[4] = 1'b1;
        @(negedge clock); sender[4] = 1'b0;
        #1;
        checks++;
        if (free[4] !== 1'b0) begin errors++; $display("FAIL release_early: free=%b, required bit 4 low", free); end
        @(negedge clock); #1;
        checks++;
        if (free[4] !== 1'b1) begin errors++; $display("FAIL release_free: free=%b, required bit 4 high", free); end
        checks++;
        if (mux_in[14:12] !== 3'd4) begin errors++; $display("FAIL release_mux_in: got %0d, required 4", mux_in[14:12]); end
    endtask

    task automatic test_routes();
        logic [7:0] tgts[4] = '{8'h31, 8'h10, 8'h12, 8'h01};
        int         dsts[4] = '{0, 3, 2, 1};
        for (int i = 0; i < 4; i++) begin
            set_target(4, tgts[i]);
            @(negedge clock);
            request(4);
            exp_q.push_back('{4, dsts[i], cyc + 3});
            wait_drain(20);
            checks++;
            if (exp_q.size() != 0) begin errors++; $display("FAIL route_timeout: target %h not granted", tgts[i]); end
            @(negedge clock); sender[4] = 1'b1;
            @(negedge clock); sender[4] = 1'b0;
            @(negedge clock); #1;
            checks++;
            if (free !== 5'b11111) begin errors++; $display("FAIL route_release: free=%b, required 11111", free); end
        end
    endtask

    task automatic test_contention();
        int n0;
        do_reset();
        set_target(0, 8'h11);
        set_target(1, 8'h11);
        @(negedge clock);
        request(0);
        request(1);
        exp_q.push_back('{0, 4, cyc + 3});
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL contend_first: EAST not granted"); end
        sender[0] = 1'b1;
        n0 = n_grants;
        repeat (20) @(negedge clock);
        #1;
        checks++;
        if (n_grants != n0) begin errors++; $display("FAIL contend_hold: %0d extra grants, required 0", n_grants - n0); end
        checks++;
        if (free[4] !== 1'b0) begin errors++; $display("FAIL contend_busy: free=%b, required bit 4 low", free); end
        checks++;
        if (h[1] !== 1'b1) begin errors++; $display("FAIL contend_pending: h=%b, required bit 1 high", h); end
        exp_q.push_back('{1, 4, -1});
        sender[0] = 1'b0;
        wait_drain(30);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL contend_second: WEST not granted after release"); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tgts[5] = '{8'h21, 8'h01, 8'h12, 8'h10, 8'h11};
        int c0;
        do_reset();
        for (int p = 0; p < 5; p++) set_target(p, tgts[p]);
        @(negedge clock);
        c0 = cyc;
        for (int p = 0; p < 5; p++) begin
            request(p);
            exp_q.push_back('{p, p, c0 + 3 + 4 * p});
        end
        wait_drain(40);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout: %0d grants outstanding, required 0", exp_q.size()); end
        checks++;
        if (free !== 5'b00000) begin errors++; $display("FAIL b2b_free: got %b, required 00000", free); end
    endtask

    task automatic test_reset_in_grant();
        int n0;
        do_reset();
        set_target(4, 8'h11);
        @(negedge clock);
        request(4);
        exp_q.push_back('{4, 4, cyc + 3});
        wait_drain(20);
        checks++;
        if (ack_h !== 5'b10000) begin errors++; $display("FAIL rgrant_ack: got %b, required 10000 before reset", ack_h); end
        reset = 1'b0;
        #1;
        checks++;
        if (ack_h !== 5'b0) begin errors++; $display("FAIL rgrant_ack_clr: got %b, required 00000", ack_h); end
        checks++;
        if (free !== 5'b11111) begin errors++; $display("FAIL rgrant_free: got %b, required 11111", free); end
        checks++;
        if (mux_in !== 15'd0 || mux_out !== 15'd0) begin
            errors++;
            $display("FAIL rgrant_mux: mux_in=%h mux_out=%h, required 0 and 0", mux_in, mux_out);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        n0 = n_grants;
        repeat (10) @(negedge clock);
        #1;
        checks++;
        if (n_grants != n0) begin errors++; $display("FAIL rgrant_stray: %0d acks after reset, required 0", n_grants - n0); end
    endtask

    initial begin
        test_reset();
        test_local_and_release();
        test_routes();
        test_contention();
        test_back_to_back();
        test_reset_in_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
